cache_miss_ctrl: RTL and testbench

Memory-side miss handler sitting directly downstream of the data cache, between the cache and the single-port data memory. Detects read misses and dirty-victim evictions from the cache's status outputs, performs the victim write-back and line refill over a request/ready handshake to data memory, writes the fetched word back into the cache, and holds the pipeline stalled until the cache can service the access. It also keeps saturating miss and write-back counters for performance debug.

---
 rtl/cache_pkg.sv | 16 +
 rtl/sat_counter.sv | 25 ++
 rtl/cache_miss_ctrl.sv | 134 +++++++++++++
 tb/tb_cache_miss_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the data-cache miss handler.
// Holds the miss FSM state encoding and the word-alignment mask applied to pipeline addresses.
package cache_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [DATA_WIDTH_DEF-1:0] WORD_ALIGN_MASK = ~32'h3;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    REFILL,
    FILL
  } miss_state_t;

endpackage

// File: rtl/sat_counter.sv
// Performance counter that increments by one on inc; one cycle from inc to count update.
// With saturating high it clamps at all-ones, otherwise it wraps; no backpressure.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 inc,
  input  logic                 saturating,
  output logic [CNT_WIDTH-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count <= '0;
    end else if (inc && !(saturating && at_max)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss handler between data cache and memory: victim write-back, then line refill, then cache fill.
// Stall is combinational in the detect cycle; each memory phase waits on MemReady for as long as memory needs.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic                  hit,
  input  logic                  WECache,
  input  logic [DATA_WIDTH-1:0] ACache,
  input  logic [DATA_WIDTH-1:0] WDCache,
  output logic                  MemReq,
  output logic                  MemWE,
  output logic [DATA_WIDTH-1:0] MemA,
  output logic [DATA_WIDTH-1:0] MemWD,
  input  logic [DATA_WIDTH-1:0] MemRD,
  input  logic                  MemReady,
  output logic                  RefillWE,
  output logic [DATA_WIDTH-1:0] RefillA,
  output logic [DATA_WIDTH-1:0] RefillData,
  output logic                  Stall,
  output logic [CNT_WIDTH-1:0]  MissCount,
  output logic [CNT_WIDTH-1:0]  WbCount
);

  miss_state_t           state;
  logic                  pend_rd;
  logic [DATA_WIDTH-1:0] miss_addr;
  logic [DATA_WIDTH-1:0] aligned_a;
  logic                  rd_miss;
  logic                  wb_req;
  logic                  wb_done;
  logic                  store_only;

  // Detection only counts in IDLE; in other states the cache status refers to a frozen access.
  assign rd_miss    = (state == IDLE) & MemRead & ~hit;
  assign wb_req     = (state == IDLE) & WECache;
  assign aligned_a  = A & DATA_WIDTH'(WORD_ALIGN_MASK);
  assign wb_done    = (state == WB) & MemReady;
  assign Stall      = (state != IDLE) | rd_miss | wb_req;
  // Stores that hit or evict nothing are handled entirely inside the cache.
  assign store_only = MemWrite & ~WECache;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      pend_rd    <= 1'b0;
      miss_addr  <= '0;
      MemReq     <= 1'b0;
      MemWE      <= 1'b0;
      MemA       <= '0;
      MemWD      <= '0;
      RefillWE   <= 1'b0;
      RefillA    <= '0;
      RefillData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_miss || wb_req) begin
            miss_addr <= aligned_a;
            pend_rd   <= rd_miss;
          end
          if (wb_req) begin
            state  <= WB;
            MemReq <= 1'b1;
            MemWE  <= 1'b1;
            MemA   <= ACache;
            MemWD  <= WDCache;
          end else if (rd_miss && !store_only) begin
            state  <= REFILL;
            MemReq <= 1'b1;
            MemWE  <= 1'b0;
            MemA   <= aligned_a;
          end
        end
        WB: begin
          if (MemReady) begin
            if (pend_rd) begin
              state <= REFILL;
              MemWE <= 1'b0;
              MemA  <= miss_addr;
            end else begin
              state  <= IDLE;
              MemReq <= 1'b0;
              MemWE  <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (MemReady) begin
            state      <= FILL;
            MemReq     <= 1'b0;
            RefillWE   <= 1'b1;
            RefillA    <= miss_addr;
            RefillData <= MemRD;
          end
        end
        FILL: begin
          state    <= IDLE;
          RefillWE <= 1'b0;
          pend_rd  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          MemReq <= 1'b0;
          MemWE  <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .inc        (rd_miss),
    .saturating (1'b1),
    .count      (MissCount)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wb_cnt (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .inc        (wb_done),
    .saturating (1'b1),
    .count      (WbCount)
  );

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: expected memory transactions, refills and stall runs are queued at issue time.
// A memory responder supplies randomized wait states; a monitor checks everything the DUT presents.
module tb_cache_miss_ctrl;

  localparam int DW   = 32;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          MemRead = 1'b0, MemWrite = 1'b0, hit = 1'b0, WECache = 1'b0;
  logic [DW-1:0] A = '0, ACache = '0, WDCache = '0;
  logic          MemReq, MemWE, RefillWE, Stall;
  logic [DW-1:0] MemA, MemWD, RefillA, RefillData;
  logic [DW-1:0] MemRD = '0;
  logic          MemReady = 1'b0;
  logic [CW-1:0] MissCount, WbCount;

  cache_miss_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .MemRead(MemRead), .MemWrite(MemWrite), .A(A), .hit(hit),
    .WECache(WECache), .ACache(ACache), .WDCache(WDCache), .MemReq(MemReq), .MemWE(MemWE),
    .MemA(MemA), .MemWD(MemWD), .MemRD(MemRD), .MemReady(MemReady), .RefillWE(RefillWE),
    .RefillA(RefillA), .RefillData(RefillData), .Stall(Stall), .MissCount(MissCount),
    .WbCount(WbCount)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wd; } mem_t;
  typedef struct { int wt; logic [31:0] rd; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } fill_t;
  typedef struct { int len; int miss; int wb; } stall_t;

  mem_t   exp_mem_q[$];
  resp_t  resp_q[$];
  fill_t  exp_fill_q[$];
  stall_t exp_stall_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int m_miss = 0;
  int m_wb   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: serves requests in order, each with its queued wait count.
  initial begin : responder
    resp_t cur;
    bit    active;
    int    cnt;
    active = 1'b0;
    cnt    = 0;
    cur    = '{0, 32'h0};
    forever begin
      @(posedge CLK); #1;
      if (!RST_N) begin
        active   = 1'b0;
        MemReady = 1'b0;
      end else if (MemReq) begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
          if (resp_q.size() > 0) cur = resp_q.pop_front();
          else cur = '{0, $urandom};
        end
        if (cnt >= cur.wt) begin
          MemReady = 1'b1;
          MemRD    = cur.rd;
          active   = 1'b0;
        end else begin
          MemReady = 1'b0;
          MemRD    = $urandom;
          cnt++;
        end
      end else begin
        active   = 1'b0;
        MemReady = 1'($urandom_range(0, 1));
        MemRD    = $urandom;
      end
    end
  end

  initial begin : monitor
    mem_t   em;
    fill_t  ef;
    stall_t es;
    int     run;
    run = 0;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        run = 0;
      end else begin
        if (MemReq) begin
          if (exp_mem_q.size() == 0) begin
            check("memreq_unexpected", 64'(MemReq), 64'd0);
          end else begin
            em = exp_mem_q[0];
            check("mem_we", 64'(MemWE), 64'(em.we));
            check("mem_addr", 64'(MemA), 64'(em.addr));
            if (em.we) check("mem_wd", 64'(MemWD), 64'(em.wd));
            if (MemReady) void'(exp_mem_q.pop_front());
          end
        end
        if (RefillWE) begin
          if (exp_fill_q.size() == 0) begin
            check("refill_unexpected", 64'(RefillWE), 64'd0);
          end else begin
            ef = exp_fill_q.pop_front();
            check("refill_addr", 64'(RefillA), 64'(ef.addr));
            check("refill_data", 64'(RefillData), 64'(ef.data));
          end
        end
        if (Stall) begin
          run++;
        end else if (run > 0) begin
          if (exp_stall_q.size() == 0) begin
            check("stall_unexpected", 64'(run), 64'd0);
          end else begin
            es = exp_stall_q.pop_front();
            check("stall_len", 64'(run), 64'(es.len));
            check("miss_count", 64'(MissCount), 64'(es.miss));
            check("wb_count", 64'(WbCount), 64'(es.wb));
          end
          run = 0;
        end
      end
    end
  end

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  // Issues one pipeline access while the controller is idle, queues the expected outcome, then waits it out.
  task automatic access(input logic mr, input logic mw, input logic h, input logic we,
                        input logic [31:0] a, input logic [31:0] ac, input logic [31:0] wd,
                        input logic [31:0] rdata, input int ww, input int rw, input int gap);
    logic rd;
    int   len;
    rd  = mr & ~h;
    len = 0;
    if (we) begin
      exp_mem_q.push_back('{1'b1, ac, wd});
      resp_q.push_back('{ww, $urandom});
      m_wb = sat_inc(m_wb);
      len += 1 + ww;
    end
    if (rd) begin
      exp_mem_q.push_back('{1'b0, a & 32'hFFFF_FFFC, 32'h0});
      resp_q.push_back('{rw, rdata});
      exp_fill_q.push_back('{a & 32'hFFFF_FFFC, rdata});
      m_miss = sat_inc(m_miss);
      len += 2 + rw;
    end
    if (rd || we) begin
      len += 1;
      exp_stall_q.push_back('{len, m_miss, m_wb});
    end
    MemRead = mr; MemWrite = mw; hit = h; WECache = we; A = a; ACache = ac; WDCache = wd;
    @(posedge CLK); #1;
    MemRead = 1'b0; MemWrite = 1'b0; WECache = 1'b0;
    hit = 1'($urandom_range(0, 1)); A = $urandom; ACache = $urandom; WDCache = $urandom;
    repeat (((len > 0) ? len - 1 : 0) + gap) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic reset_mid_refill();
    mon_en = 1'b0;
    resp_q.push_back('{50, 32'hBAD0_BAD0});
    MemRead = 1'b1; hit = 1'b0; A = 32'h300;
    @(posedge CLK); #1;
    MemRead = 1'b0;
    @(negedge CLK);
    check("abort_memreq_before", 64'(MemReq), 64'd1);
    check("abort_mema_before", 64'(MemA), 64'h300);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("abort_memreq_after", 64'(MemReq), 64'd0);
    check("abort_refillwe_after", 64'(RefillWE), 64'd0);
    check("abort_stall_after", 64'(Stall), 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    resp_q.delete();
    m_miss = 0;
    m_wb   = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("abort_no_refill", 64'(RefillWE), 64'd0);
      check("abort_no_memreq", 64'(MemReq), 64'd0);
      check("abort_miss_cnt", 64'(MissCount), 64'd0);
    end
    @(posedge CLK); #1;
    mon_en = 1'b1;
  endtask

  initial begin : stimulus
    logic [31:0] rd0;
    logic        mr, mw, h, we;

    // Reset held with a read miss on the inputs; that miss is serviced after release.
    RST_N = 1'b0; MemRead = 1'b1; hit = 1'b0; A = 32'h10E;
    repeat (2) @(posedge CLK);
    #1;
    rd0 = $urandom;
    exp_mem_q.push_back('{1'b0, 32'h10C, 32'h0});
    resp_q.push_back('{0, rd0});
    exp_fill_q.push_back('{32'h10C, rd0});
    m_miss = 1;
    exp_stall_q.push_back('{3, 1, 0});
    RST_N  = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);
    check("rst_memreq", 64'(MemReq), 64'd0);
    check("rst_memwe", 64'(MemWE), 64'd0);
    check("rst_refillwe", 64'(RefillWE), 64'd0);
    check("rst_mema", 64'(MemA), 64'd0);
    check("rst_memwd", 64'(MemWD), 64'd0);
    check("rst_refilla", 64'(RefillA), 64'd0);
    check("rst_refilldata", 64'(RefillData), 64'd0);
    check("rst_misscount", 64'(MissCount), 64'd0);
    check("rst_wbcount", 64'(WbCount), 64'd0);
    check("rst_stall_detect", 64'(Stall), 64'd1);
    @(posedge CLK); #1;
    MemRead = 1'b0;
    @(negedge CLK);
    check("rst_next_refill_req", 64'(MemReq), 64'd1);
    repeat (3) begin
      @(posedge CLK); #1;
    end

    access(1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0, 32'hDEADBEEF, 0, 0, 2);
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h80, 32'h12345678, $urandom, 2, 2, 2);
    access(1'b0, 1'b1, 1'b0, 1'b1, 32'h44, 32'h40, 32'hCAFE_0040, $urandom, 0, 0, 2);
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0, $urandom, 0, 0, 1);
    access(1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 32'h0, $urandom, 0, 0, 1);

    reset_mid_refill();

    for (int i = 0; i < 5; i++)
      access(1'b1, 1'b0, 1'b0, 1'b0, 32'h400 + 32'(i * 4), 32'h0, 32'h0, $urandom, 0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      mr = 1'($urandom_range(0, 1));
      mw = mr ? 1'b0 : 1'($urandom_range(0, 1));
      h  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      access(mr, mw, h, we, $urandom, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 3));
    end

    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("mem_q_drained", 64'(exp_mem_q.size()), 64'd0);
    check("fill_q_drained", 64'(exp_fill_q.size()), 64'd0);
    check("stall_q_drained", 64'(exp_stall_q.size()), 64'd0);
    check("final_misscount", 64'(MissCount), 64'(m_miss));
    check("final_wbcount", 64'(WbCount), 64'(m_wb));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
